serial_addsub: RTL and testbench
================================

# serial_addsub

Bit-serial add/subtract unit with a start/done handshake. It computes the same function as the team's combinational 4-bit adder/subtractor: mode=1 gives a+b+cin, and mode=0 gives a−b+cin. The result is formed one bit per clock through a single full-adder cell rather than a parallel carry chain. It sits behind a control sequencer that issues operands and waits for completion, and it trades area for WIDTH+1 cycles of latency.

## Interface
Parameters:
- WIDTH, 4: operand width; result is WIDTH+1 bits.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted when start=1 and busy=0 at a rising edge.
- mode  in  1  1 = add, 0 = subtract; sampled at acceptance.
- cin  in  1  carry-in; sampled at acceptance.
- a  in  WIDTH  operand A, unsigned; sampled at acceptance.
- b  in  WIDTH  operand B, unsigned; sampled at acceptance.
- busy  out  1  high while a computation is in progress.
- done  out  1  one-cycle pulse when sum is updated.
- sum  out  WIDTH+1  result register; holds its value until the next done.

## Operation
- Result definition, modulo 2^(WIDTH+1):
  - mode=1: sum = a + b + cin.
  - mode=0: sum = a − b + cin, in two's complement. Example: 3−5+0 = 5'b11110.
- Operands are zero-extended to WIDTH+1 bits and captured into shift registers at acceptance.
- Subtract is realised as a + ~b_ext + 1 + cin. Because two carry-ins are possible, the carry register is 2 bits (range 0..2).
- Initial carry: mode ? cin : 1+cin.
- Per bit: t = a_bit + b'_bit + carry, where b'_bit = mode ? b_bit : ~b_bit.
  - Result bit = t[0]; new carry = t>>1.
  - LSB first; result bits shift into an internal accumulator from the MSB side.
- Final carry after bit WIDTH is discarded (modulo wrap).
- FSM:
  - IDLE: on start, capture operands, clear bit counter, go to SHIFT.
  - SHIFT: process one bit per cycle. When the counter reaches WIDTH (WIDTH+1 bits done), load sum from the accumulator, set done, go to DONE.
  - DONE: done=1 for this cycle. On start, accept new operands and go to SHIFT (back-to-back); otherwise go to IDLE.
- start while busy=1 is ignored; operand changes during SHIFT have no effect.
- Reset values: state IDLE, busy=0, done=0, sum=0, carry=0, counter=0.
- Reset mid-operation aborts immediately; no done pulse; sum returns to 0.

## Timing
- Acceptance edge E0 → busy=1 from E0 through E(WIDTH+1).
- Bits are processed at edges E1..E(WIDTH+1).
- At E(WIDTH+1): sum valid, done=1, busy=0. Latency is WIDTH+1 cycles (5 for WIDTH=4).
- done lasts exactly one cycle. Back-to-back start in the DONE cycle gives a throughput of one result per WIDTH+2 cycles.
- busy and done are registered; no combinational path from inputs to outputs.

## Structure
- Package addsub_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - MODE_ADD=1'b1, MODE_SUB=1'b0.
  - Width of the carry register (2).
- Sub-module serial_fa_cell (combinational): inputs a_bit, b_bit, 2-bit carry_in; outputs s_bit and 2-bit carry_out.
- Top level holds the FSM, bit counter ($clog2(WIDTH+1) bits), operand shift registers, accumulator and sum register.

## Test plan
- add, a=9, b=7, cin=0 → done after 5 cycles, sum=5'b10000 (16); busy high for exactly 5 cycles.
- sub, a=3, b=5, cin=0 → sum=5'b11110; sub a=5, b=3, cin=1 → sum=5'b00011 (exercises carry value 2).
- add, a=15, b=15, cin=1 → sum=5'b11111. Then sub a=0, b=15, cin=0 → sum=5'b10001.
- Pulse start with new operands mid-SHIFT → ignored; sum reflects the first request only. Back-to-back start in the DONE cycle → second result 6 cycles after the first.
- Assert rst at the third SHIFT cycle → busy=0, done never pulses, sum=0. The next request completes correctly.
- Exhaustive sweep: mode∈{0,1}, cin∈{0,1}, a,b∈0..15. Compare sum against the reference formula modulo 32; $stop on the first mismatch.

Source files
------------

// File: rtl/addsub_pkg.sv
// ============================================================================
// Module      : addsub_pkg
// Description : Shared types and constants for the bit-serial add/subtract unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b1;
  localparam logic MODE_SUB = 1'b0;

  // Subtract injects both the two's-complement +1 and cin, so carry reaches 2.
  localparam int CARRY_W = 2;

endpackage

`default_nettype wire

// File: rtl/serial_fa_cell.sv
// ============================================================================
// Module      : serial_fa_cell
// Description : One-bit full-adder cell accepting a 2-bit carry (range 0..2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_fa_cell
  import addsub_pkg::*;
(
  input  logic               a_bit,
  input  logic               b_bit,
  input  logic [CARRY_W-1:0] carry_in,
  output logic               s_bit,
  output logic [CARRY_W-1:0] carry_out
);

  logic [CARRY_W:0] w_total;

  always_comb begin
    w_total   = (CARRY_W + 1)'(a_bit) + (CARRY_W + 1)'(b_bit) + (CARRY_W + 1)'(carry_in);
    s_bit     = w_total[0];
    carry_out = w_total[CARRY_W:1];
  end

endmodule

`default_nettype wire

// File: rtl/serial_addsub.sv
// ============================================================================
// Module      : serial_addsub
// Description : Bit-serial a+b+cin / a-b+cin with start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH:0]   sum
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH:0]     b_q, b_d;
  logic               mode_q, mode_d;
  logic [CARRY_W-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH:0]     sum_q, sum_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               w_accept;
  logic               w_b_bit;
  logic               w_s_bit;
  logic [CARRY_W-1:0] w_carry_out;

  assign w_accept = start && (state_q != SHIFT);
  assign w_b_bit  = (mode_q == MODE_ADD) ? b_q[0] : ~b_q[0];

  serial_fa_cell u_fa (
    .a_bit     (a_q[0]),
    .b_bit     (w_b_bit),
    .carry_in  (carry_q),
    .s_bit     (w_s_bit),
    .carry_out (w_carry_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    carry_d = carry_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      SHIFT: begin
        a_d     = {1'b0, a_q[WIDTH:1]};
        b_d     = {1'b0, b_q[WIDTH:1]};
        carry_d = w_carry_out;
        acc_d   = {w_s_bit, acc_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        // Bit WIDTH is the last one; its carry-out is dropped (modulo wrap).
        if (cnt_q == CNT_W'(WIDTH)) begin
          sum_d   = {w_s_bit, acc_q};
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      IDLE, DONE: begin
        if (w_accept) begin
          a_d     = {1'b0, a};
          b_d     = {1'b0, b};
          mode_d  = mode;
          carry_d = (mode == MODE_ADD) ? CARRY_W'(cin) : CARRY_W'(cin) + CARRY_W'(1);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= MODE_ADD;
      carry_q <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      carry_q <= carry_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
// ============================================================================
// Module      : tb_serial_addsub
// Description : Directed vector bench for serial_addsub (WIDTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_addsub;

  logic       clk;
  logic       rst;
  logic       start;
  logic       mode;
  logic       cin;
  logic [3:0] a;
  logic [3:0] b;
  logic       busy;
  logic       done;
  logic [4:0] sum;

  int errors = 0;
  int checks = 0;

  serial_addsub #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .mode  (mode),
    .cin   (cin),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic       m;
    logic       c;
    logic [3:0] va;
    logic [3:0] vb;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issue one request and return at the negedge where done is seen.
  // lat counts rising edges after the acceptance edge; busy_n counts cycles busy was high.
  task automatic do_op(input logic m, input logic c, input logic [3:0] va, input logic [3:0] vb,
                       output logic [4:0] res, output int lat, output int busy_n);
    @(negedge clk);
    start = 1'b1; mode = m; cin = c; a = va; b = vb;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    busy_n = 0;
    while (!done && lat < 30) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    res = sum;
  endtask

  initial begin
    logic [4:0] res;
    int lat, busy_n, n;
    int ref_v;
    bit seen;

    vecs[0]  = '{1'b1, 1'b0, 4'd9,  4'd7,  5'b10000};
    vecs[1]  = '{1'b0, 1'b0, 4'd3,  4'd5,  5'b11110};
    vecs[2]  = '{1'b0, 1'b1, 4'd5,  4'd3,  5'b00011};
    vecs[3]  = '{1'b1, 1'b1, 4'd15, 4'd15, 5'b11111};
    vecs[4]  = '{1'b0, 1'b0, 4'd0,  4'd15, 5'b10001};
    vecs[5]  = '{1'b1, 1'b0, 4'd0,  4'd0,  5'd0};
    vecs[6]  = '{1'b0, 1'b0, 4'd0,  4'd0,  5'd0};
    vecs[7]  = '{1'b0, 1'b1, 4'd0,  4'd0,  5'd1};
    vecs[8]  = '{1'b1, 1'b1, 4'd15, 4'd0,  5'd16};
    vecs[9]  = '{1'b0, 1'b1, 4'd15, 4'd0,  5'd16};
    vecs[10] = '{1'b0, 1'b0, 4'd7,  4'd7,  5'd0};
    vecs[11] = '{1'b1, 1'b0, 4'd10, 4'd5,  5'd15};

    rst = 1'b1; start = 1'b0; mode = 1'b1; cin = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_sum",  int'(sum),  0);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_op(vecs[i].m, vecs[i].c, vecs[i].va, vecs[i].vb, res, lat, busy_n);
      chk($sformatf("vec%0d_sum", i), int'(res), int'(vecs[i].exp));
      chk($sformatf("vec%0d_latency", i), lat, 5);
      chk($sformatf("vec%0d_busy_cycles", i), busy_n, 5);
      chk($sformatf("vec%0d_busy_at_done", i), int'(busy), 0);
    end

    // done is a single-cycle pulse
    @(negedge clk);
    chk("done_one_cycle", int'(done), 0);
    chk("sum_holds", int'(sum), 15);

    // New start mid-SHIFT must be ignored
    @(negedge clk);
    start = 1'b1; mode = 1'b1; cin = 1'b0; a = 4'd2; b = 4'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; cin = 1'b1; a = 4'd9; b = 4'd1;
    @(negedge clk);
    start = 1'b0; a = 4'd12; b = 4'd4;
    n = 2;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("midshift_latency", n, 5);
    chk("midshift_sum", int'(sum), 5);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    chk("midshift_no_second_op", int'(seen), 0);

    // Back-to-back: second start issued in the DONE cycle
    do_op(1'b1, 1'b0, 4'd1, 4'd1, res, lat, busy_n);
    chk("b2b_first_sum", int'(res), 2);
    start = 1'b1; mode = 1'b1; cin = 1'b1; a = 4'd4; b = 4'd4;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy_after_accept", int'(busy), 1);
    n = 1;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_spacing", n, 6);
    chk("b2b_second_sum", int'(sum), 9);

    // Reset during the third SHIFT cycle aborts the operation
    @(negedge clk);
    start = 1'b1; mode = 1'b0; cin = 1'b0; a = 4'd9; b = 4'd2;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_sum",  int'(sum),  0);
    chk("abort_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", int'(seen), 0);
    do_op(1'b1, 1'b0, 4'd6, 4'd7, res, lat, busy_n);
    chk("after_abort_sum", int'(res), 13);
    chk("after_abort_latency", lat, 5);

    // Full sweep against the reference formula; stops at the first mismatch
    seen = 1'b0;
    for (int m = 0; m < 2 && !seen; m++) begin
      for (int c = 0; c < 2 && !seen; c++) begin
        for (int ia = 0; ia < 16 && !seen; ia++) begin
          for (int ib = 0; ib < 16 && !seen; ib++) begin
            do_op(m[0], c[0], ia[3:0], ib[3:0], res, lat, busy_n);
            ref_v = (m == 1) ? (ia + ib + c) : (ia - ib + c);
            ref_v = ref_v & 31;
            checks++;
            if (int'(res) != ref_v) begin
              errors++;
              seen = 1'b1;
              $display("FAIL sweep m=%0d cin=%0d a=%0d b=%0d: got %0d expected %0d",
                       m, c, ia, ib, res, ref_v);
            end
          end
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
